// File: rtl/pipelined_mul_acc.sv
// Parametrised pipelined multiplier with optional multiply-accumulate.
// The capture stage registers the operands, stage 2 forms the full product,
// the middle stages delay it, and the output stage either loads the resized
// product (MODE=0) or folds it into a wrapping accumulator (MODE=1).
module pipelined_mul_acc #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int P_WIDTH   = 24,
  parameter int NUM_STAGE = 4,
  parameter int SIGNED    = 0,
  parameter int MODE      = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
  input  logic               acc_first,
  output logic [P_WIDTH-1:0] dout,
  output logic               out_valid
);

  localparam int PW = A_WIDTH + B_WIDTH;

  // Fit the full product into the result width: truncate MSBs when narrower,
  // sign- or zero-extend when wider.
  function automatic logic [P_WIDTH-1:0] resize_prod(input logic signed [PW-1:0] p);
    logic [PW+P_WIDTH-1:0] ext;
    if (SIGNED != 0) ext = {{P_WIDTH{p[PW-1]}}, p};
    else             ext = {{P_WIDTH{1'b0}}, p};
    return ext[P_WIDTH-1:0];
  endfunction

  // Accumulator update: plain modular addition, overflow wraps silently.
  function automatic logic [P_WIDTH-1:0] wrap_add(input logic [P_WIDTH-1:0] acc,
                                                  input logic [P_WIDTH-1:0] val);
    return acc + val;
  endfunction

  logic        [A_WIDTH-1:0] r_a_p1;
  logic        [B_WIDTH-1:0] r_b_p1;
  logic                      r_vld_p1;
  logic                      r_first_p1;

  logic signed [PW-1:0]      w_a_ext;
  logic signed [PW-1:0]      w_b_ext;
  logic signed [PW-1:0]      w_prod;
  logic        [P_WIDTH-1:0] w_prod_rs;

  // Index s holds the contents of pipeline stage s (2 .. NUM_STAGE-1).
  logic signed [PW-1:0]      r_prod_pn  [2:NUM_STAGE-1];
  logic                      r_vld_pn   [2:NUM_STAGE-1];
  logic                      r_first_pn [2:NUM_STAGE-1];

  logic        [P_WIDTH-1:0] r_dout;
  logic                      r_out_vld;

  // ---- stage 1 -> stage 2: operand extension and full-width product ----
  // Extending both operands to PW bits makes the low PW bits of a single
  // PW x PW multiply correct for both signed and unsigned operands.
  assign w_a_ext = (SIGNED != 0) ? $signed({{B_WIDTH{r_a_p1[A_WIDTH-1]}}, r_a_p1})
                                 : $signed({{B_WIDTH{1'b0}}, r_a_p1});
  assign w_b_ext = (SIGNED != 0) ? $signed({{A_WIDTH{r_b_p1[B_WIDTH-1]}}, r_b_p1})
                                 : $signed({{A_WIDTH{1'b0}}, r_b_p1});
  assign w_prod  = w_a_ext * w_b_ext;

  // ---- stage NUM_STAGE-1 -> output stage: resize ----
  assign w_prod_rs = resize_prod(r_prod_pn[NUM_STAGE-1]);

  // Capture operands and sample flags; acc_first only matters with a valid sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_p1     <= '0;
      r_b_p1     <= '0;
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
    end else if (ce) begin
      r_a_p1     <= din0;
      r_b_p1     <= din1;
      r_vld_p1   <= in_valid;
      r_first_p1 <= acc_first & in_valid;
    end
  end

  // Register the product at stage 2, then delay product/valid/first to NUM_STAGE-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 2; s < NUM_STAGE; s++) begin
        r_prod_pn[s]  <= '0;
        r_vld_pn[s]   <= 1'b0;
        r_first_pn[s] <= 1'b0;
      end
    end else if (ce) begin
      r_prod_pn[2]  <= w_prod;
      r_vld_pn[2]   <= r_vld_p1;
      r_first_pn[2] <= r_first_p1;
      for (int s = 3; s < NUM_STAGE; s++) begin
        r_prod_pn[s]  <= r_prod_pn[s-1];
        r_vld_pn[s]   <= r_vld_pn[s-1];
        r_first_pn[s] <= r_first_pn[s-1];
      end
    end
  end

  // Output stage: load or accumulate on valid samples, hold across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout    <= '0;
      r_out_vld <= 1'b0;
    end else if (ce) begin
      r_out_vld <= r_vld_pn[NUM_STAGE-1];
      if (r_vld_pn[NUM_STAGE-1]) begin
        if ((MODE != 0) && !r_first_pn[NUM_STAGE-1])
          r_dout <= wrap_add(r_dout, w_prod_rs);
        else
          r_dout <= w_prod_rs;
      end
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_out_vld;

endmodule

// File: tb/tb_pipelined_mul_acc.sv
// Bench for pipelined_mul_acc: several configurations share one input stream,
// each is compared every cycle against an index-based reference model.
module tb_pipelined_mul_acc;

  localparam int N = 7;
  // Per-instance configuration, mirrored in the instance parameters below.
  localparam int CA [N] = '{16, 8, 8, 16, 16, 8, 16};
  localparam int CB [N] = '{ 8, 8, 8,  8,  8, 8,  8};
  localparam int CP [N] = '{24, 16, 8, 24, 8, 20, 40};
  localparam int CN [N] = '{ 4, 4, 4,  4,  6, 3,  8};
  localparam int CS [N] = '{ 0, 1, 1,  0,  0, 1,  1};
  localparam int CM [N] = '{ 0, 0, 0,  1,  1, 1,  0};

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic [15:0] din0;
  logic [7:0]  din1;
  logic        acc_first;

  logic [23:0] d0;  logic ov0;
  logic [15:0] d1;  logic ov1;
  logic [7:0]  d2;  logic ov2;
  logic [23:0] d3;  logic ov3;
  logic [7:0]  d4;  logic ov4;
  logic [19:0] d5;  logic ov5;
  logic [39:0] d6;  logic ov6;

  pipelined_mul_acc #(.A_WIDTH(16), .B_WIDTH(8), .P_WIDTH(24), .NUM_STAGE(4), .SIGNED(0), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_first(acc_first), .dout(d0), .out_valid(ov0));
  pipelined_mul_acc #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(16), .NUM_STAGE(4), .SIGNED(1), .MODE(0)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0[7:0]), .din1(din1),
    .acc_first(acc_first), .dout(d1), .out_valid(ov1));
  pipelined_mul_acc #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(8), .NUM_STAGE(4), .SIGNED(1), .MODE(0)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0[7:0]), .din1(din1),
    .acc_first(acc_first), .dout(d2), .out_valid(ov2));
  pipelined_mul_acc #(.A_WIDTH(16), .B_WIDTH(8), .P_WIDTH(24), .NUM_STAGE(4), .SIGNED(0), .MODE(1)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_first(acc_first), .dout(d3), .out_valid(ov3));
  pipelined_mul_acc #(.A_WIDTH(16), .B_WIDTH(8), .P_WIDTH(8), .NUM_STAGE(6), .SIGNED(0), .MODE(1)) u4 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_first(acc_first), .dout(d4), .out_valid(ov4));
  pipelined_mul_acc #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(20), .NUM_STAGE(3), .SIGNED(1), .MODE(1)) u5 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0[7:0]), .din1(din1),
    .acc_first(acc_first), .dout(d5), .out_valid(ov5));
  pipelined_mul_acc #(.A_WIDTH(16), .B_WIDTH(8), .P_WIDTH(40), .NUM_STAGE(8), .SIGNED(1), .MODE(0)) u6 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_first(acc_first), .dout(d6), .out_valid(ov6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: history of inputs indexed by enabled edge since reset.
  localparam int HMAX = 8192;
  bit     hv [HMAX];
  int     ha [HMAX];
  int     hb [HMAX];
  bit     hf [HMAX];
  int     n;
  longint macc [N];
  bit     mvld [N];
  int     cnt_ov0;
  longint got3[$];
  longint got4[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] get_dout(input int i);
    case (i)
      0: return 64'(d0);
      1: return 64'(d1);
      2: return 64'(d2);
      3: return 64'(d3);
      4: return 64'(d4);
      5: return 64'(d5);
      default: return 64'(d6);
    endcase
  endfunction

  function automatic logic get_ov(input int i);
    case (i)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      3: return ov3;
      4: return ov4;
      5: return ov5;
      default: return ov6;
    endcase
  endfunction

  // Arithmetic meaning of one sample for configuration i, given the previous output.
  function automatic longint model_out(input int i, input longint acc, input int a,
                                       input int b, input bit f);
    longint am, bm, pm, r;
    am = longint'(a) & ((longint'(1) << CA[i]) - 1);
    bm = longint'(b) & ((longint'(1) << CB[i]) - 1);
    if (CS[i] != 0 && am >= (longint'(1) << (CA[i] - 1))) am -= (longint'(1) << CA[i]);
    if (CS[i] != 0 && bm >= (longint'(1) << (CB[i] - 1))) bm -= (longint'(1) << CB[i]);
    pm = (longint'(1) << CP[i]) - 1;
    r  = (am * bm) & pm;
    if (CM[i] != 0 && !f) r = (acc + r) & pm;
    return r;
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("ov%0d", i), 64'(get_ov(i)), 64'(mvld[i]));
      check($sformatf("dout%0d", i), get_dout(i), 64'(macc[i]));
    end
  endtask

  task automatic clear_model();
    n = 0;
    for (int i = 0; i < N; i++) begin
      macc[i] = 0;
      mvld[i] = 1'b0;
    end
  endtask

  // One clock: drive inputs, advance the model on enabled edges, check all outputs.
  task automatic step(input bit v, input int a, input int b, input bit f, input bit c);
    int idx;
    in_valid = v; din0 = a[15:0]; din1 = b[7:0]; acc_first = f; ce = c;
    @(posedge clk);
    if (reset && c && n < HMAX) begin
      hv[n] = v; ha[n] = a; hb[n] = b; hf[n] = f;
      n++;
      for (int i = 0; i < N; i++) begin
        idx = n - CN[i];
        if (idx >= 0 && hv[idx]) begin
          mvld[i] = 1'b1;
          macc[i] = model_out(i, macc[i], ha[idx], hb[idx], hf[idx]);
        end else begin
          mvld[i] = 1'b0;
        end
      end
    end
    #1;
    check_all();
    if (ov0) cnt_ov0++;
    if (ov3) got3.push_back(longint'(d3));
    if (ov4) got4.push_back(longint'(d4));
  endtask

  task automatic bubbles(input int k);
    for (int j = 0; j < k; j++) step(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  // Assert reset asynchronously mid-cycle, check the immediate clear, then release.
  task automatic do_reset();
    reset = 1'b0;
    clear_model();
    #1;
    check_all();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 5, 5, 1'b0, 1'b1);
    reset = 1'b1;
  endtask

  longint e3 [4] = '{30, 50, 54, 49};
  longint e4 [2] = '{200, 44};

  initial begin
    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; acc_first = 1'b0;
    cnt_ov0 = 0;
    clear_model();
    #2;
    do_reset();

    // Largest unsigned operands, single sample, exact latency and single-cycle valid.
    step(1'b1, 'hFFFF, 'hFF, 1'b0, 1'b1);
    bubbles(3);
    check("p1_dout", 64'(d0), 64'h00FEFF01);
    check("p1_ov_on", 64'(ov0), 64'd1);
    bubbles(1);
    check("p1_ov_off", 64'(ov0), 64'd0);
    bubbles(8);

    // Signed products, wide and truncated result.
    step(1'b1, 'hFD, 5, 1'b0, 1'b1);
    bubbles(9);
    check("p2_neg_w", 64'(d1), 64'hFFF1);
    check("p2_neg_t", 64'(d2), 64'hF1);
    step(1'b1, 'h80, 'h80, 1'b0, 1'b1);
    bubbles(9);
    check("p2_min_w", 64'(d1), 64'h4000);
    check("p2_min_t", 64'(d2), 64'h00);

    // Accumulation with restart and a bubble in the stream.
    got3.delete();
    step(1'b1, 10, 3, 1'b1, 1'b1);
    step(1'b1, 4, 5, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 2, 2, 1'b0, 1'b1);
    step(1'b1, 7, 7, 1'b1, 1'b1);
    bubbles(10);
    check("p3_n", 64'(got3.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < got3.size()) check($sformatf("p3_acc%0d", k), 64'(got3[k]), 64'(e3[k]));

    // Accumulator wrap at 8 bits.
    got4.delete();
    step(1'b1, 200, 1, 1'b1, 1'b1);
    step(1'b1, 100, 1, 1'b0, 1'b1);
    bubbles(10);
    check("p4_n", 64'(got4.size()), 64'd2);
    for (int k = 0; k < 2; k++)
      if (k < got4.size()) check($sformatf("p4_acc%0d", k), 64'(got4[k]), 64'(e4[k]));

    // Clock-enable freeze mid-flight; junk inputs while frozen must be ignored.
    step(1'b1, 1234, 56, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) step(1'b1, int'($urandom), int'($urandom), 1'b0, 1'b0);
    check("p5_frozen_ov", 64'(ov0), 64'd0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    check("p5_ov", 64'(ov0), 64'd1);
    check("p5_dout", 64'(d0), 64'd69104);
    bubbles(10);

    // Back-to-back random samples: count outputs, then reset while outputs stream.
    cnt_ov0 = 0;
    for (int j = 0; j < 103; j++)
      step(1'b1, int'($urandom), int'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    check("p1_cnt", 64'(cnt_ov0), 64'd100);
    do_reset();
    bubbles(10);

    // First sample after reset without restart accumulates onto zero.
    step(1'b1, 6, 7, 1'b0, 1'b1);
    bubbles(8);
    check("p6_acc0", 64'(d3), 64'd42);

    // Random traffic with bubbles and ce gaps.
    for (int j = 0; j < 300; j++)
      step(1'($urandom_range(0, 3) != 0), int'($urandom), int'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0));
    bubbles(10);

    // Reset mid-flight after two of three samples.
    step(1'b1, 300, 7, 1'b1, 1'b1);
    step(1'b1, 301, 9, 1'b0, 1'b1);
    do_reset();
    bubbles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_mul_acc.md
Name: pipelined_mul_acc

Overview:
- Parametrised successor to the fixed 16x8 pipelined unsigned multiplier used by the pooling/conv kernels.
- Configurable operand/result widths, signedness and pipeline depth.
- Adds per-sample valid tracking and an optional multiply-accumulate mode with a per-sample restart flag.
- Sits between the HLS datapath and the DSP48 inference point. Used for address/index products (MODE=0) and dot-product partial sums (MODE=1).

Parameters:
- A_WIDTH, 16, din0 width.
- B_WIDTH, 8, din1 width.
- P_WIDTH, 24, dout/accumulator width. Legal range: 2..A_WIDTH+B_WIDTH+16.
- NUM_STAGE, 4, register stages from din to dout. Legal range: 3..8.
- SIGNED, 0. 0 = unsigned operands; 1 = two's-complement operands.
- MODE, 0. 0 = multiply only; 1 = multiply-accumulate.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; freezes the entire pipeline when low.
- in_valid  in  1  din0/din1/acc_first carry a sample this cycle.
- din0  in  A_WIDTH  operand A.
- din1  in  B_WIDTH  operand B.
- acc_first  in  1  MODE=1 only: this sample restarts the accumulation. Ignored when MODE=0.
- dout  out  P_WIDTH  product (MODE=0) or running sum (MODE=1).
- out_valid  out  1  dout was updated by a valid sample on the last enabled edge.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers, the accumulator, dout and out_valid are cleared to 0 immediately. Reset mid-operation discards every in-flight sample. The first output after release comes only from samples accepted after release.
- ce=0: no register changes, including the valid/first shift chain. dout and out_valid hold their values.
- Capture: on an edge with ce=1, the stage-1 registers load din0, din1, in_valid and acc_first. in_valid=0 samples still propagate, as bubbles.
- Stage 2: full product of width A_WIDTH+B_WIDTH, computed signed or unsigned per SIGNED.
- Stages 3..NUM_STAGE-1: pure delay of product, valid and first.
- Stage NUM_STAGE (output register):
  - MODE=0, valid sample: dout <= product resized to P_WIDTH. Truncate MSBs if narrower; zero-extend (SIGNED=0) or sign-extend (SIGNED=1) if wider.
  - MODE=1, valid sample with first=1: acc <= resized product.
  - MODE=1, valid sample with first=0: acc <= acc + resized product, wrapping modulo 2^P_WIDTH. No saturation and no overflow flag.
  - MODE=1: dout is the accumulator.
  - Bubble (valid=0): dout/acc hold. Bubbles never modify the accumulator.
- out_valid <= valid bit of stage NUM_STAGE-1 on every ce=1 edge.
- Latency: a sample captured on enabled edge k appears on dout, with out_valid=1, after enabled edge k+NUM_STAGE-1, i.e. NUM_STAGE enabled edges including the capture. Throughput is 1 sample/cycle. Back-to-back valid samples produce back-to-back outputs.
- MODE=1, first valid sample after reset with acc_first=0: it accumulates onto 0.
- acc_first is sampled only when in_valid=1.
- No backpressure: downstream must accept every out_valid pulse, or hold ce low.

Test Plan:
1. Defaults (16x8 unsigned, NUM_STAGE=4, MODE=0): din0=0xFFFF, din1=0xFF, one valid cycle -> dout=0xFEFF01, out_valid high for exactly 1 cycle, 4 enabled edges after capture edge inclusive. Then apply 100 random back-to-back samples -> every output matches a*b in order, with no gaps.
2. SIGNED=1, A=8, B=8, P=16: -3 x 5 -> dout=0xFFF1. Then -128 x -128 -> 0x4000. Repeat with P_WIDTH=8 -> dout=0xF1 and 0x00 (truncation).
3. MODE=1, P=24: samples (first=1, 10x3), (0, 4x5), bubble, (0, 2x2), (first=1, 7x7) -> out_valid pulses with dout 30, 50, 54, 49. dout holds 50 during the bubble cycle.
4. MODE=1 wrap, P=8 unsigned: (first=1, 200x1), (0, 100x1) -> dout 200 then 44.
5. ce gating: capture one sample, drop ce for 5 cycles mid-flight -> dout/out_valid frozen. The result appears after 3 further enabled edges, unchanged.
6. Reset mid-flight: inject 3 valid samples, assert reset after the 2nd enabled edge -> dout=0 and out_valid=0 immediately, no stale outputs after release. MODE=1: the next sample with first=0 accumulates from 0.
